// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the TX packet arbiter.
//   tx_arb_state_t : arbiter FSM state (IDLE waits for an admissible packet,
//                    STREAM copies the granted packet into the TX FIFO)
//   MAX_REQ        : largest requester count the arbiter supports
//   onehot()       : index -> one-hot vector, MAX_REQ bits wide
package tx_arb_pkg;

  typedef enum logic {IDLE, STREAM} tx_arb_state_t;

  localparam int unsigned MAX_REQ = 8;

  // Callers keep the low NUM_REQ bits of the result.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/tx_arb_rr_pick.sv
// Combinational round-robin first-set finder.
// Scans the eligible mask starting at rr_ptr and wrapping. It returns the
// first set position it finds.
//   eligible : in  NUM_REQ  requesters that may be granted this cycle
//   rr_ptr   : in  IW       scan start position
//   index    : out IW       first eligible position at or after rr_ptr
//   found    : out 1        at least one eligible requester exists
module tx_arb_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      index,
  output logic               found
);

  int unsigned pos;

  always_comb begin
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!found && eligible[pos]) begin
        found = 1'b1;
        index = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// TX packet arbiter. It shares the single UART TX byte FIFO between NUM_REQ
// packet sources and is the FIFO's only writer. A packet is admitted only
// when the FIFO's free count covers its whole length. An admitted packet
// is streamed contiguously, so packets never interleave in the FIFO.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   req           : in  source i has a packet pending, held until done/err
//   req_len       : in  packet length of source i, slice [i*(ADDR_BITS+1) +: ADDR_BITS+1]
//   src_valid     : in  byte valid from source i
//   src_data      : in  byte of source i, slice [i*8 +: 8]
//   src_ready     : out byte accepted from the granted source (at most one bit)
//   grant         : out one-hot owner of the FIFO
//   done          : out pulse with the last byte of the granted packet
//   err           : out pulse when a requesting source has length 0 or > DEPTH
//   busy          : out arbiter is streaming a packet
//   fifo_wr_en    : out FIFO write strobe
//   fifo_wr_data  : out FIFO write byte
//   fifo_full     : in  FIFO full
//   fifo_free     : in  FIFO free entries, already reflecting last cycle's write
module tx_pkt_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*(ADDR_BITS+1)-1:0] req_len,
  input  logic [NUM_REQ-1:0]             src_valid,
  input  logic [NUM_REQ*8-1:0]           src_data,
  output logic [NUM_REQ-1:0]             src_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             err,
  output logic                           busy,
  output logic                           fifo_wr_en,
  output logic [7:0]                     fifo_wr_data,
  input  logic                           fifo_full,
  input  logic [ADDR_BITS:0]             fifo_free
);

  localparam int unsigned LW = ADDR_BITS + 1;
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Per-source views of the packed length and data buses.
  logic [LW-1:0] len_arr  [NUM_REQ];
  logic [7:0]    data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign len_arr[i]  = req_len[i*LW +: LW];
    assign data_arr[i] = src_data[i*8 +: 8];
  end

  // A length is legal when it is non-zero and fits in an empty FIFO.
  logic [NUM_REQ-1:0] legal;
  logic [NUM_REQ-1:0] eligible;

  always_comb begin
    legal = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      legal[i] = (len_arr[i] != '0) && (len_arr[i] <= LW'(DEPTH));
    end
  end

  assign eligible = req & legal;

  tx_arb_state_t      state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic [MAX_REQ-1:0] pick_oh;
  logic               xfer;

  tx_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .index    (pick_idx),
    .found    (pick_found)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    src_ready    = '0;
    done         = '0;
    err          = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    xfer         = 1'b0;
    pick_oh      = '0;

    case (state_q)
      IDLE: begin
        err = req & ~legal;
        // Head-of-line: a candidate too long for the current free space
        // blocks everyone else, so long packets cannot be starved.
        if (pick_found && (len_arr[pick_idx] <= fifo_free)) begin
          pick_oh = onehot(3'(pick_idx));
          state_d = STREAM;
          grant_d = pick_oh[NUM_REQ-1:0];
          gidx_d  = pick_idx;
          cnt_d   = len_arr[pick_idx];
        end
      end

      STREAM: begin
        // Full should not happen after the admission check, but if it does
        // the byte is held at the source rather than dropped.
        src_ready = grant_q & {NUM_REQ{~fifo_full}};
        xfer      = src_valid[gidx_q] & ~fifo_full;
        if (xfer) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = data_arr[gidx_q];
          cnt_d        = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            done     = grant_q;
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == STREAM);

endmodule
